uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//  Transmit-side buffer directly upstream of the UART transmitter.
//  - Queues bytes written by the host and issues one start pulse per byte to the transmitter.
//  - Pops the next byte only after the transmitter reports completion.
//  - Lets the host burst-write up to 2**ADDR_W bytes without polling the serial line.
// PARAMETERS
//  DBIT    8  data bits per word; must match the transmitter's DBIT
//  ADDR_W  4  FIFO address width; depth = 2**ADDR_W words
// PORTS
//  i_clk           in   1         system clock, rising edge
//  i_reset_n       in   1         asynchronous reset, active low
//  i_wr            in   1         host write strobe, one word per cycle
//  i_wr_data       in   DBIT      host write data
//  o_full          out  1         FIFO holds 2**ADDR_W words
//  o_empty         out  1         FIFO holds 0 words
//  o_count         out  ADDR_W+1  words currently queued
//  i_tx_done_tick  in   1         one-cycle completion pulse from the transmitter
//  o_tx_start      out  1         one-cycle start pulse to the transmitter
//  o_tx_data       out  DBIT      word for the transmitter; stable from o_tx_start until the next start
//  o_busy          out  1         a word is handed off and completion is pending
// BEHAVIOUR
//  Reset (async, i_reset_n=0)
//   - Pointers, count and FSM clear; the FSM enters IDLE.
//   - Outputs: o_tx_start=0, o_tx_data=0, o_busy=0, o_empty=1, o_full=0, o_count=0.
//   - Reset in mid-operation discards all queued words. A transmitter frame already in flight is
//     not aborted; its later done tick arrives while the FSM is in IDLE and is ignored.
//  Storage and pointers
//   - Register-array storage.
//   - wr_ptr and rd_ptr are ADDR_W+1 bits wide; they wrap modulo 2**(ADDR_W+1).
//   - Full when the pointers differ only in the MSB.
//   - Empty when the pointers are equal.
//   - o_count = wr_ptr - rd_ptr, computed at ADDR_W+1 bits.
//  Write
//   - Accepted at the clock edge when i_wr=1 and o_full=0.
//   - A write while full is dropped and the FIFO is unchanged. This holds even if a pop happens
//     in the same cycle, because full is evaluated from registered state.
//  FSM, two states
//   - IDLE: o_busy=0. When o_empty=0, at the next edge:
//     - o_tx_data <= mem[rd_ptr];
//     - o_tx_start <= 1 for exactly one cycle;
//     - rd_ptr increments (pop);
//     - state -> WAIT.
//   - WAIT: o_busy=1. Stays in WAIT until i_tx_done_tick=1, then returns to IDLE at that edge.
//   - i_tx_done_tick received in IDLE is ignored.
//  Latency
//   - A word written into an empty FIFO at edge N is visible on o_tx_start/o_tx_data after edge N+1.
//   - Back-to-back words: done tick at edge M; the next o_tx_start rises after edge M+1, which is one
//     idle cycle and matches the transmitter's return to its idle state.
//  Simultaneous events
//   - Accepted write and pop in the same cycle: both happen and o_count is unchanged.
//   - A write into an empty FIFO cannot be popped in the same cycle; there is no bypass path.
// CONFIGURATION
//  UART_TX_FIFO_OVF_EN
//   - Defined: adds input i_ovf_clr (1 bit) and output o_ovf (1 bit, resets to 0).
//     - o_ovf sets on any i_wr while o_full=1.
//     - o_ovf clears on i_ovf_clr=1.
//     - If set and clear occur in the same cycle, set wins.
//   - Undefined: neither port exists; dropped writes are silent.
// TESTING
//  1 Reset: hold i_reset_n=0 with i_wr=1 -> o_empty=1, o_count=0, o_tx_start=0, o_busy=0.
//  2 Single byte: write 8'hA5 at edge N -> o_tx_start=1 and o_tx_data=8'hA5 for one cycle after N+1;
//    o_busy=1 until done tick; o_count returns to 0.
//  3 Burst: write 8'h01..8'h05 back-to-back, done tick 20 cycles after each start -> five start
//    pulses, data 01..05 in order, each start exactly 2 cycles after the preceding done tick's edge.
//  4 Full/wrap: ADDR_W=2, write 6 words without done ticks ->
//    - 1 popped, 4 queued, o_full=1, 6th dropped;
//    - then drain and refill 3 times -> pointer wrap yields correct data order and o_count.
//  5 Simultaneous: pop and accepted write in the same cycle -> o_count unchanged. Done tick in IDLE
//    with an empty FIFO -> no start pulse.
//  6 Reset mid-WAIT with 3 words queued -> all cleared, no further o_tx_start. With
//    UART_TX_FIFO_OVF_EN: write while full -> o_ovf=1; i_ovf_clr -> o_ovf=0.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte queue in front of a UART transmitter; one start pulse per queued byte.
// Latency: write at edge N -> o_tx_start/o_tx_data after N+1; next start one idle cycle after a done tick.
// Backpressure: writes while o_full are dropped (flagged on o_ovf when UART_TX_FIFO_OVF_EN is defined).
module uart_tx_fifo #(
    parameter int DBIT   = 8,
    parameter int ADDR_W = 4
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_wr,
    input  logic [DBIT-1:0]   i_wr_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [ADDR_W:0]   o_count,
    input  logic              i_tx_done_tick,
    output logic              o_tx_start,
    output logic [DBIT-1:0]   o_tx_data,
    output logic              o_busy
`ifdef UART_TX_FIFO_OVF_EN
    ,
    input  logic              i_ovf_clr,
    output logic              o_ovf
`endif
);

    localparam int               DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0]  PTR_INC = (ADDR_W + 1)'(1);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    logic [DBIT-1:0]  r_mem [DEPTH];
    logic [ADDR_W:0]  r_wr_ptr;
    logic [ADDR_W:0]  r_rd_ptr;
    state_t           r_state;
    logic             r_tx_start;
    logic [DBIT-1:0]  r_tx_data;
    logic             r_busy;

    logic             w_full;
    logic             w_empty;
    logic             w_wr_en;
    logic             w_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_full  = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                     (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_wr_en = i_wr && !w_full;
    assign w_pop   = (r_state == ST_IDLE) && !w_empty;

    assign o_full     = w_full;
    assign o_empty    = w_empty;
    assign o_count    = r_wr_ptr - r_rd_ptr;
    assign o_tx_start = r_tx_start;
    assign o_tx_data  = r_tx_data;
    assign o_busy     = r_busy;

    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr_ptr <= '0;
        end else if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + PTR_INC;
        end
    end

    // Done ticks arriving in IDLE (e.g. a frame that outlived a reset) are ignored.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= ST_IDLE;
            r_rd_ptr   <= '0;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_tx_data  <= r_mem[r_rd_ptr[ADDR_W-1:0]];
                        r_tx_start <= 1'b1;
                        r_rd_ptr   <= r_rd_ptr + PTR_INC;
                        r_busy     <= 1'b1;
                        r_state    <= ST_WAIT;
                    end else begin
                        r_tx_start <= 1'b0;
                        r_busy     <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    r_tx_start <= 1'b0;
                    if (i_tx_done_tick) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_tx_start <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef UART_TX_FIFO_OVF_EN
    logic r_ovf;

    assign o_ovf = r_ovf;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_ovf <= 1'b0;
        end else if (i_wr && w_full) begin
            r_ovf <= 1'b1;
        end else if (i_ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo built with ADDR_W=2 (depth 4) so full and pointer wrap are reachable.
module tb_uart_tx_fifo;

    localparam int DBIT   = 8;
    localparam int ADDR_W = 2;

    logic              clk;
    logic              rst_n;
    logic              wr;
    logic [DBIT-1:0]   wr_data;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              done;
    logic              start;
    logic [DBIT-1:0]   tx_data;
    logic              busy;
`ifdef UART_TX_FIFO_OVF_EN
    logic              ovf_clr;
    logic              ovf;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    uart_tx_fifo #(
        .DBIT   (DBIT),
        .ADDR_W (ADDR_W)
    ) dut (
        .i_clk          (clk),
        .i_reset_n      (rst_n),
        .i_wr           (wr),
        .i_wr_data      (wr_data),
        .o_full         (full),
        .o_empty        (empty),
        .o_count        (count),
        .i_tx_done_tick (done),
        .o_tx_start     (start),
        .o_tx_data      (tx_data),
        .o_busy         (busy)
`ifdef UART_TX_FIFO_OVF_EN
        ,
        .i_ovf_clr      (ovf_clr),
        .o_ovf          (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a start pulse, check its word and width, then return a done tick.
    task automatic xmit_expect(input logic [7:0] exp, input string tag);
        int n;
        n = 0;
        while (start !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk({tag, "_start"}, 32'(start), 32'd1);
        chk({tag, "_data"}, 32'(tx_data), 32'(exp));
        step();
        chk({tag, "_pulse"}, 32'(start), 32'd0);
        done = 1'b1;
        step();
        done = 1'b0;
    endtask

    initial begin
        int d;
        int n;
        int starts;
        logic [7:0] base;

        rst_n   = 1'b0;
        wr      = 1'b1;
        wr_data = 8'hFF;
        done    = 1'b0;
`ifdef UART_TX_FIFO_OVF_EN
        ovf_clr = 1'b0;
`endif

        // Reset held with a write strobe active
        step();
        step();
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_data", 32'(tx_data), 32'd0);
`ifdef UART_TX_FIFO_OVF_EN
        chk("rst_ovf", 32'(ovf), 32'd0);
`endif
        wr    = 1'b0;
        rst_n = 1'b1;
        step();

        // Single byte
        wr      = 1'b1;
        wr_data = 8'hA5;
        step();
        wr = 1'b0;
        chk("single_count_n", 32'(count), 32'd1);
        chk("single_nobypass", 32'(start), 32'd0);
        step();
        chk("single_start", 32'(start), 32'd1);
        chk("single_data", 32'(tx_data), 32'hA5);
        chk("single_busy", 32'(busy), 32'd1);
        chk("single_count_pop", 32'(count), 32'd0);
        step();
        chk("single_pulse", 32'(start), 32'd0);
        step();
        step();
        chk("single_busy_hold", 32'(busy), 32'd1);
        chk("single_data_hold", 32'(tx_data), 32'hA5);
        done = 1'b1;
        step();
        done = 1'b0;
        chk("single_busy_clr", 32'(busy), 32'd0);
        step();
        chk("single_no_restart", 32'(start), 32'd0);

        // Done tick in IDLE with an empty FIFO
        done = 1'b1;
        step();
        done = 1'b0;
        step();
        chk("idle_done_start", 32'(start), 32'd0);
        chk("idle_done_busy", 32'(busy), 32'd0);

        // Burst of five, done tick 20 cycles after each start
        for (int i = 1; i <= 5; i++) begin
            wr      = 1'b1;
            wr_data = 8'(i);
            step();
            if (i == 2) begin
                chk("burst_first_start", 32'(start), 32'd1);
                chk("burst_first_data", 32'(tx_data), 32'd1);
            end
        end
        wr = 1'b0;
        d  = 0;
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) begin
                n = 0;
                while (start !== 1'b1 && n < 40) begin
                    step();
                    n++;
                end
                chk("burst_start", 32'(start), 32'd1);
                chk("burst_data", 32'(tx_data), 32'(k));
                chk("burst_gap", 32'(cyc - d), 32'd2);
            end
            for (int j = 0; j < 19; j++) step();
            chk("burst_busy", 32'(busy), 32'd1);
            done = 1'b1;
            d    = cyc;
            step();
            done = 1'b0;
        end
        step();
        chk("burst_empty", 32'(empty), 32'd1);
        chk("burst_count", 32'(count), 32'd0);

        // Full: six writes, no done ticks
        for (int i = 0; i < 6; i++) begin
            wr      = 1'b1;
            wr_data = 8'(8'h10 + i);
            step();
        end
        wr = 1'b0;
        chk("full_count", 32'(count), 32'd4);
        chk("full_flag", 32'(full), 32'd1);
        chk("full_busy", 32'(busy), 32'd1);
        chk("full_data", 32'(tx_data), 32'h10);
        done = 1'b1;
        step();
        done = 1'b0;
        // Write while full in the same cycle as a pop: still dropped
        wr      = 1'b1;
        wr_data = 8'h16;
        step();
        wr = 1'b0;
        chk("fullpop_count", 32'(count), 32'd3);
        chk("fullpop_start", 32'(start), 32'd1);
        chk("fullpop_data", 32'(tx_data), 32'h11);
        chk("fullpop_full", 32'(full), 32'd0);
        step();
        done = 1'b1;
        step();
        done = 1'b0;
        xmit_expect(8'h12, "drain0");
        xmit_expect(8'h13, "drain1");
        xmit_expect(8'h14, "drain2");
        step();
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_count", 32'(count), 32'd0);
        chk("drain_no_dropped", 32'(start), 32'd0);

        // Refill and drain three times across the pointer wrap
        for (int r = 0; r < 3; r++) begin
            base = 8'(8'h20 + 16 * r);
            for (int j = 0; j < 4; j++) begin
                wr      = 1'b1;
                wr_data = 8'(base + j);
                step();
                if (j == 1) begin
                    chk("simul_count", 32'(count), 32'd1);
                    chk("wrap_first_start", 32'(start), 32'd1);
                    chk("wrap_first_data", 32'(tx_data), 32'(base));
                end
            end
            wr = 1'b0;
            chk("wrap_count", 32'(count), 32'd3);
            chk("wrap_full", 32'(full), 32'd0);
            step();
            done = 1'b1;
            step();
            done = 1'b0;
            xmit_expect(8'(base + 1), "wrap_w1");
            xmit_expect(8'(base + 2), "wrap_w2");
            xmit_expect(8'(base + 3), "wrap_w3");
            step();
            chk("wrap_empty", 32'(empty), 32'd1);
        end

        // Reset in WAIT with three words queued
        for (int i = 0; i < 4; i++) begin
            wr      = 1'b1;
            wr_data = 8'(8'h40 + i);
            step();
        end
        wr = 1'b0;
        chk("midrst_pre_count", 32'(count), 32'd3);
        chk("midrst_pre_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #2;
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_empty", 32'(empty), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_start", 32'(start), 32'd0);
        chk("midrst_data", 32'(tx_data), 32'd0);
        rst_n  = 1'b1;
        starts = 0;
        for (int j = 0; j < 10; j++) begin
            done = (j == 2);
            step();
            if (start === 1'b1) starts++;
        end
        done = 1'b0;
        chk("midrst_no_start", 32'(starts), 32'd0);
        chk("midrst_post_count", 32'(count), 32'd0);

`ifdef UART_TX_FIFO_OVF_EN
        // Overflow flag
        for (int i = 0; i < 5; i++) begin
            wr      = 1'b1;
            wr_data = 8'(8'h50 + i);
            step();
        end
        chk("ovf_full", 32'(full), 32'd1);
        chk("ovf_clear_before", 32'(ovf), 32'd0);
        step();
        wr = 1'b0;
        chk("ovf_set", 32'(ovf), 32'd1);
        chk("ovf_count", 32'(count), 32'd4);
        ovf_clr = 1'b1;
        step();
        chk("ovf_clr", 32'(ovf), 32'd0);
        wr = 1'b1;
        step();
        wr = 1'b0;
        chk("ovf_set_wins", 32'(ovf), 32'd1);
        step();
        chk("ovf_clr2", 32'(ovf), 32'd0);
        ovf_clr = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
